// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: parity codes and FSM encoding.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_e;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational requester picker; UART_TX_SCHED_FIXED_PRIO_EN selects lowest-index-wins,
// otherwise round-robin starting at ptr.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx
);

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    logic ptr_unused;
    assign ptr_unused = ^ptr;

    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                idx    = IW'(k);
            end
        end
    end
`else
    always_comb begin
        int   j;
        logic found;
        j     = 0;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among N_REQ producers with start timeout and inter-frame gap.
// Macro UART_TX_SCHED_FIXED_PRIO_EN: fixed lowest-index priority, no round-robin pointer.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int N_REQ         = 4,
    parameter  int DATA_W        = 8,
    parameter  int START_TIMEOUT = 1023,
    parameter  int GAP_CYCLES    = 16,
    localparam int IW            = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ*2-1:0]        req_parity,
    output logic [N_REQ-1:0]          grant,
    output logic [DATA_W-1:0]         tx_data,
    output logic [1:0]                tx_parity,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [IW-1:0]             active_id,
    output logic                      sched_busy,
    output logic                      timeout_err
);

    localparam int TW = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

    sched_state_e        state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [1:0]          tx_parity_q, tx_parity_d;
    logic                tx_start_q, tx_start_d;
    logic [IW-1:0]       active_id_q, active_id_d;
    logic                sched_busy_q, sched_busy_d;
    logic                timeout_err_q, timeout_err_d;
    logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
    logic                sync_q, sync_d;

    logic [N_REQ-1:0]    arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic [IW-1:0]       rr_ptr;
    logic                grant_ok;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // After reset a frame may still be on the wire; hold grants until tx_busy is seen low.
    assign grant_ok = (state_q == ST_IDLE) && (|req) && !(sync_q && tx_busy);

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_ok) begin
            ptr_d = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

    assign rr_ptr = ptr_q;
`endif

    always_comb begin
        state_d       = state_q;
        grant_d       = '0;
        tx_data_d     = tx_data_q;
        tx_parity_d   = tx_parity_q;
        tx_start_d    = tx_start_q;
        active_id_d   = active_id_q;
        timeout_err_d = 1'b0;
        tmo_cnt_d     = tmo_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        sync_d        = sync_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!tx_busy) sync_d = 1'b0;
                if (grant_ok) begin
                    grant_d     = arb_gnt;
                    tx_data_d   = req_data[arb_idx*DATA_W +: DATA_W];
                    tx_parity_d = req_parity[arb_idx*2 +: 2];
                    tx_start_d  = 1'b1;
                    active_id_d = arb_idx;
                    tmo_cnt_d   = '0;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = ST_WAIT;
                end else if (tmo_cnt_q == TW'(START_TIMEOUT)) begin
                    tx_start_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (!tx_busy) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
                else gap_cnt_d = gap_cnt_q + 1'b1;
            end
        endcase
        sched_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            tx_data_q     <= '0;
            tx_parity_q   <= PARITY_NONE;
            tx_start_q    <= 1'b0;
            active_id_q   <= '0;
            sched_busy_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            tmo_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            sync_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            tx_data_q     <= tx_data_d;
            tx_parity_q   <= tx_parity_d;
            tx_start_q    <= tx_start_d;
            active_id_q   <= active_id_d;
            sched_busy_q  <= sched_busy_d;
            timeout_err_q <= timeout_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            sync_q        <= sync_d;
        end
    end

    assign grant       = grant_q;
    assign tx_data     = tx_data_q;
    assign tx_parity   = tx_parity_q;
    assign tx_start    = tx_start_q;
    assign active_id   = active_id_q;
    assign sched_busy  = sched_busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed scoreboard bench for uart_tx_scheduler (4 requesters, timeout 15, gap 4).
module tb_uart_tx_scheduler;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int TMO   = 15;
    localparam int GAP   = 4;
    localparam int FRAME = 3;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic [1:0] par;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N*2-1:0] req_parity = '0;
    logic [N-1:0]   grant;
    logic [W-1:0]   tx_data;
    logic [1:0]     tx_parity;
    logic           tx_start;
    logic           tx_busy;
    logic [1:0]     active_id;
    logic           sched_busy;
    logic           timeout_err;

    logic           man_busy = 1'b0;
    logic           xm_en = 1'b0;
    logic           xm_busy = 1'b0;
    int             xm_cnt = 0;

    exp_t           q[$];
    int             n_checks = 0;
    int             n_fail = 0;

    assign tx_busy = xm_en ? xm_busy : man_busy;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .N_REQ(N), .DATA_W(W), .START_TIMEOUT(TMO), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .req_parity(req_parity), .grant(grant), .tx_data(tx_data),
        .tx_parity(tx_parity), .tx_start(tx_start), .tx_busy(tx_busy),
        .active_id(active_id), .sched_busy(sched_busy),
        .timeout_err(timeout_err)
    );

    // Transmitter model: busy for FRAME cycles after seeing tx_start.
    always @(posedge clk) begin
        if (!xm_en) begin
            xm_busy <= 1'b0;
            xm_cnt  <= 0;
        end else if (xm_cnt != 0) begin
            xm_cnt <= xm_cnt - 1;
            if (xm_cnt == 1) xm_busy <= 1'b0;
        end else if (tx_start && !xm_busy) begin
            xm_busy <= 1'b1;
            xm_cnt  <= FRAME;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [7:0] d, input logic [1:0] p);
        req_data[i*W +: W]  = d;
        req_parity[i*2 +: 2] = p;
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic [1:0] p);
        exp_t e;
        e.id = i;
        e.data = d;
        e.par = p;
        q.push_back(e);
    endtask

    task automatic wait_grant(input string tag, output int lat);
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (grant != 0) break;
        end
        chk({tag, "_seen"}, 32'(grant != 0), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (sched_busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sched_busy), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_start"}, 32'(tx_start), 0);
        chk({tag, "_data"}, 32'(tx_data), 0);
        chk({tag, "_par"}, 32'(tx_parity), 0);
        chk({tag, "_id"}, 32'(active_id), 0);
        chk({tag, "_busy"}, 32'(sched_busy), 0);
        chk({tag, "_tmo"}, 32'(timeout_err), 0);
    endtask

    // Scoreboard: every grant is compared against the oldest expected byte.
    always @(negedge clk) begin
        if (rst && grant !== '0) begin
            if (q.size() == 0) begin
                chk("unexpected_grant", 32'(grant), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_grant", 32'(grant), 32'(1) << e.id);
                chk("sb_data", 32'(tx_data), 32'(e.data));
                chk("sb_par", 32'(tx_parity), 32'(e.par));
                chk("sb_id", 32'(active_id), 32'(e.id));
                chk("sb_start", 32'(tx_start), 1);
                chk("sb_busy", 32'(sched_busy), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        logic any;

        #23;
        chk_zero("in_rst");
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk_zero("post_rst");

        // Single request on lane 2
        set_lane(2, 8'hD2, 2'd2);
        req = 4'b0100;
        push(2, 8'hD2, 2'd2);
        wait_grant("single", lat);
        chk("single_lat", 32'(lat), 1);
        req = '0;
        @(negedge clk);
        chk("grant_pulse", 32'(grant), 0);
        chk("start_hold1", 32'(tx_start), 1);
        @(negedge clk);
        chk("start_hold2", 32'(tx_start), 1);

        // Lane 1 pending while frame runs; lane 2 data changes after grant
        set_lane(1, 8'h5A, 2'd1);
        req = 4'b0010;
        push(1, 8'h5A, 2'd1);
        set_lane(2, 8'h11, 2'd0);
        man_busy = 1'b1;
        @(negedge clk);
        chk("start_drop", 32'(tx_start), 0);
        chk("wait_busy", 32'(sched_busy), 1);
        chk("data_stable", 32'(tx_data), 32'hD2);
        chk("par_stable", 32'(tx_parity), 2);
        @(negedge clk) man_busy = 1'b0;
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            if (sched_busy && !tx_start && grant == 0) n++;
            else break;
        end
        chk("gap_len", 32'(n), GAP);
        chk("gap_idle", 32'(sched_busy), 0);
        wait_grant("b2b", lat);
        chk("b2b_lat", 32'(lat), 1);
        req = '0;

        // Lane 1 grant never acknowledged: start timeout
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (timeout_err) break;
        end
        chk("tmo_cycles", 32'(n), TMO + 1);
        chk("tmo_start", 32'(tx_start), 0);
        chk("tmo_idle", 32'(sched_busy), 0);
        @(negedge clk);
        chk("tmo_pulse", 32'(timeout_err), 0);
        chk("tmo_no_regrant", 32'(grant), 0);

        // Reset during WAIT, transmitter still busy afterwards
        set_lane(3, 8'h3C, 2'd3);
        req = 4'b1000;
        push(3, 8'h3C, 2'd3);
        wait_grant("pre_rst", lat);
        req = '0;
        man_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("in_wait", 32'(sched_busy), 1);
        #2 rst = 1'b0;
        #1 chk_zero("mid_rst");
        set_lane(0, 8'hA5, 2'd0);
        req = 4'b0001;
        push(0, 8'hA5, 2'd0);
        @(negedge clk) rst = 1'b1;
        any = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (grant != 0 || sched_busy) any = 1'b1;
        end
        chk("hold_off", 32'(any), 0);
        man_busy = 1'b0;
        wait_grant("after_rst", lat);
        chk("after_rst_lat", 32'(lat), 1);
        req = '0;
        man_busy = 1'b1;
        @(negedge clk) man_busy = 1'b0;
        wait_idle("after_rst_idle");

        // Contention with transmitter model, from a fresh pointer
        rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < N; i++) set_lane(i, 8'(8'h10 + i), 2'(i));
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
        for (int k = 0; k < 5; k++) push(0, 8'h10, 2'd0);
`else
        for (int k = 0; k < 5; k++) push(k % N, 8'(8'h10 + (k % N)), 2'(k % N));
`endif
        xm_en = 1'b1;
        req = 4'b1111;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        req = '0;
        chk("contention_done", 32'(q.size()), 0);
        @(negedge clk);
        wait_idle("final_idle");
        xm_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
